// File: rtl/rx_event_monitor.sv
// rx_event_monitor
//   Monitors NUM_EVENTS abnormal-signal event lines from the RX chain.
//   Provides per-event saturating rising-edge counters with global and
//   per-event clear and a global freeze. It also captures the first event
//   seen since the last clear, and generates a maskable receiver reset with
//   a programmable hold-off window.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   enable             global enable for receiver_rst generation
//   power_trigger      packet-in-progress qualifier for receiver_rst
//   event_in           level event lines, bit i = event i
//   event_en_mask      1 = event i is counted / eligible for capture and reset
//   rst_mask           1 = event i may trigger receiver_rst
//   holdoff_len        cycles receiver_rst re-triggering is suppressed
//   freeze             1 = counters hold their value
//   clear_sel          pulse: clear counter addressed by event_selector
//   clear_all          pulse: clear all counters and the first-event latch
//   event_selector     readback / clear index
//   event_counter      registered count of the selected event (1-cycle latency)
//   first_event_id     lowest index of the first edge since last clear
//   first_event_valid  first_event_id is meaningful
//   receiver_rst       one-cycle receiver reset pulse
//
// NUM_EVENTS must not exceed 2**SEL_WIDTH.
module rx_event_monitor #(
  parameter int NUM_EVENTS    = 8,
  parameter int SEL_WIDTH     = 3,
  parameter int COUNTER_WIDTH = 22,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic                     power_trigger,
  input  logic [NUM_EVENTS-1:0]    event_in,
  input  logic [NUM_EVENTS-1:0]    event_en_mask,
  input  logic [NUM_EVENTS-1:0]    rst_mask,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_len,
  input  logic                     freeze,
  input  logic                     clear_sel,
  input  logic                     clear_all,
  input  logic [SEL_WIDTH-1:0]     event_selector,
  output logic [COUNTER_WIDTH-1:0] event_counter,
  output logic [SEL_WIDTH-1:0]     first_event_id,
  output logic                     first_event_valid,
  output logic                     receiver_rst
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_EVENTS-1:0]    hist_q, hist_d;
  logic [NUM_EVENTS-1:0]    evt_edge;
  logic [NUM_EVENTS-1:0]    clr;
  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] cnt_d [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] event_counter_q, event_counter_d;
  logic [SEL_WIDTH-1:0]     first_id_q, first_id_d;
  logic                     first_vld_q, first_vld_d;
  logic [SEL_WIDTH-1:0]     lowest_idx;
  logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
  logic                     rst_pulse_q, rst_pulse_d;
  logic                     trig;

  assign evt_edge = event_in & event_en_mask & ~hist_q;

  // Per-event clear select. Selectors beyond NUM_EVENTS match no lane, so an
  // out-of-range clear_sel is naturally ignored.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      clr[i] = clear_all | (clear_sel & (event_selector == SEL_WIDTH'(i)));
    end
  end

  // Counter and history next state. A clear beats a simultaneous edge.
  always_comb begin
    hist_d = event_in;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i]) begin
        cnt_d[i]  = '0;
        hist_d[i] = 1'b0;
      end else if (evt_edge[i] && !freeze && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
      end
    end
  end

  // Readback mux; out-of-range selectors read 0.
  always_comb begin
    event_counter_d = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (event_selector == SEL_WIDTH'(i)) event_counter_d = cnt_q[i];
    end
  end

  // Lowest-index priority encoder over this cycle's edges.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (evt_edge[i]) lowest_idx = SEL_WIDTH'(i);
    end
  end

  // First-event latch ignores freeze; only clear_all re-arms it.
  always_comb begin
    first_id_d  = first_id_q;
    first_vld_d = first_vld_q;
    if (clear_all) begin
      first_vld_d = 1'b0;
    end else if (!first_vld_q && (|evt_edge)) begin
      first_id_d  = lowest_idx;
      first_vld_d = 1'b1;
    end
  end

  // Level-sensitive trigger; hold keeps counting down even when disabled.
  assign trig = enable & power_trigger & (|(event_in & event_en_mask & rst_mask));

  always_comb begin
    rst_pulse_d = 1'b0;
    hold_d      = hold_q;
    if (trig && (hold_q == '0)) begin
      rst_pulse_d = 1'b1;
      hold_d      = holdoff_len;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLDOFF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q          <= '0;
      event_counter_q <= '0;
      first_id_q      <= '0;
      first_vld_q     <= 1'b0;
      hold_q          <= '0;
      rst_pulse_q     <= 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
    end else begin
      hist_q          <= hist_d;
      event_counter_q <= event_counter_d;
      first_id_q      <= first_id_d;
      first_vld_q     <= first_vld_d;
      hold_q          <= hold_d;
      rst_pulse_q     <= rst_pulse_d;
      for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign event_counter     = event_counter_q;
  assign first_event_id    = first_id_q;
  assign first_event_valid = first_vld_q;
  assign receiver_rst      = rst_pulse_q;

endmodule

// File: tb/tb_rx_event_monitor.sv
module tb_rx_event_monitor;

  localparam int N    = 8;
  localparam int SW   = 3;
  localparam int CW   = 4;
  localparam int HW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, enable, power_trigger, freeze, clear_sel, clear_all;
  logic [N-1:0]  event_in, event_en_mask, rst_mask;
  logic [HW-1:0] holdoff_len;
  logic [SW-1:0] event_selector;
  logic [CW-1:0] event_counter;
  logic [SW-1:0] first_event_id;
  logic          first_event_valid, receiver_rst;

  rx_event_monitor #(
    .NUM_EVENTS(N), .SEL_WIDTH(SW), .COUNTER_WIDTH(CW), .HOLDOFF_WIDTH(HW)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .power_trigger(power_trigger),
    .event_in(event_in), .event_en_mask(event_en_mask), .rst_mask(rst_mask),
    .holdoff_len(holdoff_len), .freeze(freeze), .clear_sel(clear_sel),
    .clear_all(clear_all), .event_selector(event_selector),
    .event_counter(event_counter), .first_event_id(first_event_id),
    .first_event_valid(first_event_valid), .receiver_rst(receiver_rst)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural reference state
  int m_level[N];
  int m_cnt[N];
  int m_ec, m_fid, m_fv, m_rst, m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock using the current inputs.
  task automatic model_clock();
    int  rising[N];
    int  sel;
    bit  any_trig;
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin m_level[i] = 0; m_cnt[i] = 0; end
      m_ec = 0; m_fid = 0; m_fv = 0; m_rst = 0; m_hold = 0;
      return;
    end
    sel = int'(event_selector);
    for (int i = 0; i < N; i++)
      rising[i] = (event_in[i] && event_en_mask[i] && m_level[i] == 0) ? 1 : 0;
    m_ec = (sel < N) ? m_cnt[sel] : 0;
    if (clear_all) m_fv = 0;
    else if (m_fv == 0) begin
      for (int i = N - 1; i >= 0; i--)
        if (rising[i] == 1) begin m_fid = i; m_fv = 1; end
    end
    for (int i = 0; i < N; i++) begin
      if (clear_all || (clear_sel && sel == i)) begin
        m_cnt[i] = 0; m_level[i] = 0;
      end else begin
        m_level[i] = event_in[i];
        if (rising[i] == 1 && !freeze && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    any_trig = enable && power_trigger && ((event_in & event_en_mask & rst_mask) != 0);
    if (any_trig && m_hold == 0) begin m_rst = 1; m_hold = int'(holdoff_len); end
    else begin m_rst = 0; if (m_hold > 0) m_hold = m_hold - 1; end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    chk("event_counter", 32'(event_counter), 32'(m_ec));
    chk("first_event_id", 32'(first_event_id), 32'(m_fid));
    chk("first_event_valid", 32'(first_event_valid), 32'(m_fv));
    chk("receiver_rst", 32'(receiver_rst), 32'(m_rst));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int pulse_at[$];
  int cyc;

  initial begin
    rstn = 1'b0; enable = 1'b0; power_trigger = 1'b0; freeze = 1'b0;
    clear_sel = 1'b0; clear_all = 1'b0; event_in = '0; event_en_mask = '1;
    rst_mask = '0; holdoff_len = '0; event_selector = 3'd2;
    for (int i = 0; i < N; i++) begin m_level[i] = 0; m_cnt[i] = 0; end
    m_ec = 0; m_fid = 0; m_fv = 0; m_rst = 0; m_hold = 0;

    // Reset
    steps(2);
    chk("reset_counter", 32'(event_counter), 0);
    chk("reset_valid", 32'(first_event_valid), 0);
    chk("reset_rst", 32'(receiver_rst), 0);
    rstn = 1'b1;
    step();

    // Five 3-high/3-low pulses on event 2
    for (int p = 0; p < 5; p++) begin
      event_in[2] = 1'b1; steps(3);
      event_in[2] = 1'b0; steps(3);
    end
    step();
    chk("cnt2_five", 32'(event_counter), 5);
    chk("first_id_2", 32'(first_event_id), 2);
    chk("first_valid_2", 32'(first_event_valid), 1);
    for (int s = 0; s < N; s++) begin
      if (s != 2) begin
        event_selector = SW'(s); steps(2);
        chk("other_sel_zero", 32'(event_counter), 0);
      end
    end

    // Simultaneous rise on 1 and 5, then 1 again
    clear_all = 1'b1; step(); clear_all = 1'b0; step();
    event_in[1] = 1'b1; event_in[5] = 1'b1; steps(2);
    event_in = '0; steps(2);
    event_in[1] = 1'b1; steps(2);
    event_in[1] = 1'b0; steps(2);
    event_selector = 3'd1; steps(2);
    chk("cnt1_two", 32'(event_counter), 2);
    event_selector = 3'd5; steps(2);
    chk("cnt5_one", 32'(event_counter), 1);
    chk("first_id_1", 32'(first_event_id), 1);
    clear_all = 1'b1; step(); clear_all = 1'b0; steps(2);
    chk("cleared_cnt5", 32'(event_counter), 0);
    chk("cleared_valid", 32'(first_event_valid), 0);
    event_in[5] = 1'b1; steps(2); event_in[5] = 1'b0; step();
    chk("first_id_5", 32'(first_event_id), 5);

    // Saturation on event 0, then clear_sel racing an edge
    event_selector = 3'd0;
    for (int p = 0; p < 20; p++) begin
      event_in[0] = 1'b1; step(); event_in[0] = 1'b0; step();
    end
    step();
    chk("cnt0_saturated", 32'(event_counter), CMAX);
    event_in[0] = 1'b1; clear_sel = 1'b1; step();
    event_in[0] = 1'b0; clear_sel = 1'b0; step();
    chk("clear_sel_beats_edge", 32'(event_counter), 0);

    // Freeze on event 3
    event_selector = 3'd3; freeze = 1'b1;
    for (int p = 0; p < 3; p++) begin
      event_in[3] = 1'b1; steps(2); event_in[3] = 1'b0; steps(2);
    end
    event_in[3] = 1'b1; steps(2); freeze = 1'b0; steps(3);
    event_in[3] = 1'b0; steps(2);
    chk("freeze_no_count", 32'(event_counter), 0);
    event_in[3] = 1'b1; steps(2); event_in[3] = 1'b0; steps(2);
    chk("after_freeze_plus1", 32'(event_counter), 1);

    // Reset generator with hold-off 4
    enable = 1'b1; power_trigger = 1'b1; rst_mask = 8'h04; holdoff_len = 16'd4;
    event_selector = 3'd2; event_in[2] = 1'b1;
    pulse_at.delete();
    for (cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (receiver_rst === 1'b1) pulse_at.push_back(cyc);
    end
    event_in[2] = 1'b0; steps(2);
    chk("rst_pulse_count", 32'(pulse_at.size()), 4);
    for (int k = 0; k < pulse_at.size() && k < 4; k++)
      chk("rst_pulse_cycle", 32'(pulse_at[k]), 32'(1 + 5 * k));
    rst_mask = '0; event_in[2] = 1'b1;
    pulse_at.delete();
    for (cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (receiver_rst === 1'b1) pulse_at.push_back(cyc);
    end
    event_in[2] = 1'b0; steps(2);
    chk("rst_masked_no_pulse", 32'(pulse_at.size()), 0);
    chk("cnt2_unaffected", 32'(event_counter), 2);

    // Reset mid-holdoff
    rst_mask = 8'h04; event_in[2] = 1'b1; steps(3);
    rstn = 1'b0; step();
    chk("midrst_counter", 32'(event_counter), 0);
    chk("midrst_valid", 32'(first_event_valid), 0);
    chk("midrst_id", 32'(first_event_id), 0);
    chk("midrst_rst", 32'(receiver_rst), 0);
    rstn = 1'b1; step();
    chk("post_reset_trigger", 32'(receiver_rst), 1);
    event_in = '0; steps(2);

    // Randomized traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      event_in       = event_in ^ N'($urandom & $urandom);
      event_en_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      rst_mask       = N'($urandom);
      enable         = ($urandom_range(0, 3) != 0);
      power_trigger  = ($urandom_range(0, 3) != 0);
      holdoff_len    = HW'($urandom_range(0, 5));
      freeze         = ($urandom_range(0, 7) == 0);
      clear_sel      = ($urandom_range(0, 15) == 0);
      clear_all      = ($urandom_range(0, 31) == 0);
      event_selector = SW'($urandom);
      rstn           = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_event_monitor.md
Name: rx_event_monitor

Overview:
- Parametrised successor to the receiver's abnormal-signal event counting: monitors NUM_EVENTS independent abnormal-signal event lines from the OpenOFDM RX chain (DC watchdog, equalizer monitor, phase-offset monitor, signal-length checks, …).
- Provides per-event rising-edge counting, global and per-event clear and freeze, first-event capture, and a maskable receiver-reset generator with a programmable hold-off window.
- Sits between the RX detectors and the AXI register file.

Parameters:
- NUM_EVENTS, 8, number of event inputs (1..2**SEL_WIDTH).
- SEL_WIDTH, 3, width of event_selector and first_event_id.
- COUNTER_WIDTH, 22, width of each per-event counter.
- HOLDOFF_WIDTH, 16, width of hold-off length and down-counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- enable  in  1  global enable for receiver_rst generation.
- power_trigger  in  1  packet-in-progress qualifier for receiver_rst.
- event_in  in  NUM_EVENTS  level event lines, bit i = event i.
- event_en_mask  in  NUM_EVENTS  1 = event i is counted and eligible for first-event capture and reset.
- rst_mask  in  NUM_EVENTS  1 = event i may trigger receiver_rst.
- holdoff_len  in  HOLDOFF_WIDTH  cycles receiver_rst re-triggering is suppressed after a pulse.
- freeze  in  1  1 = counters hold their value.
- clear_sel  in  1  one-cycle pulse: clear the counter addressed by event_selector.
- clear_all  in  1  one-cycle pulse: clear all counters and the first-event latch.
- event_selector  in  SEL_WIDTH  readback and clear index.
- event_counter  out  COUNTER_WIDTH  registered count of the selected event.
- first_event_id  out  SEL_WIDTH  index of the first event seen since the last clear.
- first_event_valid  out  1  first_event_id is meaningful.
- receiver_rst  out  1  one-cycle receiver reset pulse.

Behaviour:
- Reset: on rstn=0 at a clk edge, clear all counters, edge history, the hold-off counter, event_counter, first_event_id, first_event_valid and receiver_rst.
- Edge detect, per i: edge[i] = event_in[i] & event_en_mask[i] & ~hist[i]. hist[i] is a registered copy of event_in[i] and updates every cycle, including under freeze.
- Counting: on edge[i] with freeze=0, cnt[i] increments by 1. It saturates at 2**COUNTER_WIDTH-1 and never wraps.
- Clear: clear_all clears every cnt and hist; clear_sel clears cnt[event_selector] and hist[event_selector] only. A clear has priority over a simultaneous edge: the result is 0. clear_sel with event_selector >= NUM_EVENTS has no effect.
- Freeze: an edge occurring while freeze=1 is lost. Deasserting freeze while a level is held causes no count.
- Readback: event_counter = cnt[event_selector], registered, 1-cycle latency. It reads 0 for event_selector >= NUM_EVENTS. After an increment at edge N, the new value is visible on event_counter at edge N+1.
- First-event latch:
  - While first_event_valid=0, the first cycle with any edge loads first_event_id = lowest index i with edge[i] and sets first_event_valid=1. Both outputs are registered.
  - The latch then holds until clear_all or reset. clear_all on the same cycle as an edge: clear wins and valid stays 0.
  - freeze does not affect this latch.
- Reset generator, registered:
  - trig = enable & power_trigger & |(event_in & event_en_mask & rst_mask). This is level-sensitive, not edge.
  - If trig and hold==0: receiver_rst=1 next cycle and hold loads holdoff_len.
  - Otherwise receiver_rst=0, and hold decrements when nonzero.
  - With holdoff_len=0 and trig held, receiver_rst is 1 every cycle.
  - With holdoff_len=H and trig held, pulses are spaced H+1 cycles.
  - enable=0 does not clear hold; the decrement continues.
- No counter or latch state depends on enable or power_trigger.

Test Plan:
- Reset, then event_in[2] pulses 5 times, 3 cycles high and 3 low each, mask=0xFF, selector=2 -> event_counter=5; other selectors read 0; first_event_id=2, first_event_valid=1.
- event_in[1] and event_in[5] rise on the same cycle, then event_in[1] re-pulses -> first_event_id=1, cnt1=2, cnt5=1. clear_all -> all counts 0, valid=0. The next event_in[5] rise -> id=5.
- COUNTER_WIDTH=4, 20 rising edges on event 0 -> count saturates at 15. clear_sel with selector=0 on the same cycle as an edge -> count 0.
- freeze=1 during 3 pulses on event 3, freeze released while event_in[3] is high -> count unchanged. The next full pulse -> +1.
- enable=power_trigger=1, rst_mask=0x04, event_in[2] held high 20 cycles, holdoff_len=4 -> receiver_rst pulses on cycles 1, 6, 11, 16. Repeat with rst_mask=0 -> no pulses, but counting is unaffected.
- rstn=0 mid-holdoff with counts non-zero -> all outputs 0 the next cycle. After release, trig fires receiver_rst immediately.
